seq_pattern_gen: RTL

//  Serial bit-pattern transmitter: latches a parallel pattern, emits it MSB-first on
//  one serial line, one bit per clock, optionally repeated. Drives the stimulus end
//  of the serial sequence-detector path (x -> detector), replacing hand-written
//  per-bit stimulus with a start/busy/done handshake.

---
 rtl/seq_pattern_gen_pkg.sv | 17 +
 rtl/seq_pattern_gen_if.sv | 20 ++
 rtl/seq_pattern_shreg.sv | 31 +++
 rtl/seq_pattern_gen.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seq_pattern_gen_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package seq_pattern_gen_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_DONE} state_e;

  // A zero or oversize length selects the full register width.
  function automatic int unsigned eff_len(int unsigned len, int unsigned w);
    return (len == 0 || len > w) ? w : len;
  endfunction

  function automatic int unsigned eff_rep(int unsigned rep);
    return (rep == 0) ? 1 : rep;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/serial-output bundle between a stimulus source and seq_pattern_gen.
interface seq_pattern_gen_if
  import seq_pattern_gen_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LEN_W = $clog2(W + 1),
  parameter int REP_W = 4
);
  logic             start;
  logic [W-1:0]     pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] rep;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (output start, pattern, len, rep, input x, x_valid, busy, done);
  modport slave  (input start, pattern, len, rep, output x, x_valid, busy, done);
endinterface

// File: rtl/seq_pattern_shreg.sv
// Loadable left-aligning shift register; exposes the MSB it will hold next cycle.
module seq_pattern_shreg #(
  parameter int W     = 16,
  parameter int LEN_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [W-1:0]     pattern_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             msb_d_o
);
  logic [W-1:0]     data_q, data_d;
  logic [LEN_W-1:0] shamt;

  assign shamt = LEN_W'(W) - len_i;

  always_comb begin
    data_d = data_q;
    if (load_i)       data_d = pattern_i << shamt;
    else if (shift_i) data_d = {data_q[W-2:0], 1'b0};
  end

  // Lets the parent register x without an extra cycle of latency.
  assign msb_d_o = data_d[W-1];

  always_ff @(posedge clk or posedge reset)
    if (reset) data_q <= '0;
    else       data_q <= data_d;
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter, MSB-first, optional repeat.
// Build option: PARITY_EN appends an even-parity bit after every repetition.
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LEN_W = $clog2(W + 1),
  parameter int REP_W = 4
) (
  input logic            clk,
  input logic            reset,
  seq_pattern_gen_if.slave bus
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] bcnt_q, bcnt_d, len_q, len_d;
  logic [REP_W-1:0] rcnt_q, rcnt_d;
  logic [W-1:0]     pat_q, pat_d;
  logic             x_q, x_d, xv_q, busy_q, done_q;
  logic             ld, sh, rld, msb_d;
  logic [W-1:0]     ld_pat;
  logic [LEN_W-1:0] ld_len, in_len;
  logic [REP_W-1:0] in_rep;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  assign in_len = LEN_W'(eff_len(32'(bus.len), 32'(W)));
  assign in_rep = REP_W'(eff_rep(32'(bus.rep)));

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    len_d   = len_q;
    pat_d   = pat_q;
    ld      = 1'b0;
    sh      = 1'b0;
    rld     = 1'b0;
    ld_pat  = pat_q;
    ld_len  = len_q;
`ifdef PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start) begin
        ld      = 1'b1;
        ld_pat  = bus.pattern;
        ld_len  = in_len;
        pat_d   = bus.pattern;
        len_d   = in_len;
        bcnt_d  = in_len - LEN_W'(1);
        rcnt_d  = in_rep - REP_W'(1);
        state_d = S_SHIFT;
`ifdef PARITY_EN
        par_d   = 1'b0;
`endif
      end
      S_SHIFT: begin
`ifdef PARITY_EN
        par_d = par_q ^ x_q;
`endif
        if (bcnt_q != '0) begin
          sh     = 1'b1;
          bcnt_d = bcnt_q - LEN_W'(1);
        end else begin
`ifdef PARITY_EN
          state_d = S_PAR;
`else
          if (rcnt_q != '0) rld = 1'b1;
          else              state_d = S_DONE;
`endif
        end
      end
      S_PAR:
        if (rcnt_q != '0) rld = 1'b1;
        else              state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Next repetition starts straight from the latched copy, no idle gap.
    if (rld) begin
      ld      = 1'b1;
      bcnt_d  = len_q - LEN_W'(1);
      rcnt_d  = rcnt_q - REP_W'(1);
      state_d = S_SHIFT;
`ifdef PARITY_EN
      par_d   = 1'b0;
`endif
    end
  end

`ifdef PARITY_EN
  assign x_d = (state_d == S_SHIFT) ? msb_d : ((state_d == S_PAR) & (par_q ^ x_q));
`else
  assign x_d = (state_d == S_SHIFT) & msb_d;
`endif

  seq_pattern_shreg #(.W(W), .LEN_W(LEN_W)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load_i   (ld),
    .shift_i  (sh),
    .pattern_i(ld_pat),
    .len_i    (ld_len),
    .msb_d_o  (msb_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      x_q     <= x_d;
      xv_q    <= (state_d == S_SHIFT) || (state_d == S_PAR);
      busy_q  <= (state_d == S_SHIFT) || (state_d == S_PAR);
      done_q  <= (state_d == S_DONE);
    end
  end

`ifdef PARITY_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) par_q <= 1'b0;
    else       par_q <= par_d;
`endif

  assign bus.x       = x_q;
  assign bus.x_valid = xv_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
